// File: rtl/dma_bus_arbiter.sv
// Bus handoff sequencer between a CPU and a DMA controller: staged hold/release
// of command and address enables with guard delays and a minimum CPU tenure.
module dma_bus_arbiter #(
    parameter int GUARD_CYCLES   = 1,
    parameter int MIN_CPU_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] s_n,
    input  logic       lock_n,
    input  logic       hrq,
    output logic       hlda,
    output logic       aen_n,
    output logic       cen,
    output logic       dma_aen,
    output logic       cpu_rdy
);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_CEN_OFF,
        ST_AEN_OFF,
        ST_DMA,
        ST_REL_AEN,
        ST_REL_CEN
    } state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);
    localparam logic [7:0] MIN_LOAD   = 8'(MIN_CPU_CYCLES);
    // Output vector order: {hlda, aen_n, cen, dma_aen, cpu_rdy}
    localparam logic [4:0] OUT_CPU    = 5'b00101;

    state_t     state_q, state_d;
    logic [3:0] guard_q, guard_d;
    logic [7:0] mincnt_q, mincnt_d;
    logic [4:0] out_q, out_d;

    function automatic logic [4:0] decode_outputs(input state_t s);
        case (s)
            ST_CPU:     decode_outputs = OUT_CPU;
            ST_CEN_OFF: decode_outputs = 5'b00000;
            ST_AEN_OFF: decode_outputs = 5'b01010;
            ST_DMA:     decode_outputs = 5'b11010;
            ST_REL_AEN: decode_outputs = 5'b01010;
            ST_REL_CEN: decode_outputs = 5'b00000;
            default:    decode_outputs = OUT_CPU;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        mincnt_d = mincnt_q;
        case (state_q)
            ST_CPU: begin
                if (mincnt_q != 8'd0) mincnt_d = mincnt_q - 8'd1;
                if (hrq && (s_n == 3'b111) && lock_n && (mincnt_q == 8'd0)) begin
                    state_d = ST_CEN_OFF;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_CEN_OFF: begin
                // A withdrawn request backs out before the address bus is touched
                if (!hrq) begin
                    state_d = ST_CPU;
                end else if (guard_q == 4'd0) begin
                    state_d = ST_AEN_OFF;
                    guard_d = GUARD_LOAD;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            ST_AEN_OFF: begin
                if (!hrq) begin
                    state_d = ST_REL_CEN;
                    guard_d = GUARD_LOAD;
                end else if (guard_q == 4'd0) begin
                    state_d = ST_DMA;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            ST_DMA: begin
                if (!hrq) begin
                    state_d = ST_REL_AEN;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_REL_AEN: begin
                if (guard_q == 4'd0) begin
                    state_d = ST_REL_CEN;
                    guard_d = GUARD_LOAD;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            ST_REL_CEN: begin
                if (guard_q == 4'd0) begin
                    state_d  = ST_CPU;
                    mincnt_d = MIN_LOAD;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: state_d = ST_CPU;
        endcase
        // Outputs follow the next state so they change on the same edge as the state
        out_d = decode_outputs(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_CPU;
            guard_q  <= 4'd0;
            mincnt_q <= 8'd0;
            out_q    <= OUT_CPU;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            mincnt_q <= mincnt_d;
            out_q    <= out_d;
        end
    end

    assign {hlda, aen_n, cen, dma_aen, cpu_rdy} = out_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter at GUARD_CYCLES=1, MIN_CPU_CYCLES=4.
module tb_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] s_n = 3'b111;
    logic       lock_n = 1'b1;
    logic       hrq = 1'b0;
    logic       hlda, aen_n, cen, dma_aen, cpu_rdy;
    logic [4:0] outs;
    int         n_checks = 0;
    int         n_fail = 0;

    // Expected output vectors {hlda, aen_n, cen, dma_aen, cpu_rdy}
    localparam logic [4:0] O_CPU  = 5'b00101;
    localparam logic [4:0] O_CENO = 5'b00000;
    localparam logic [4:0] O_AENO = 5'b01010;
    localparam logic [4:0] O_DMA  = 5'b11010;

    dma_bus_arbiter #(.GUARD_CYCLES(1), .MIN_CPU_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .s_n(s_n), .lock_n(lock_n), .hrq(hrq),
        .hlda(hlda), .aen_n(aen_n), .cen(cen), .dma_aen(dma_aen), .cpu_rdy(cpu_rdy)
    );

    assign outs = {hlda, aen_n, cen, dma_aen, cpu_rdy};

    always #5 clk = ~clk;

    // Bus-ownership invariant, sampled every cycle on the inactive edge
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (hlda && !(aen_n && !cen)) begin
                n_fail++;
                $display("FAIL invariant_hlda: got outs=%b required aen_n=1 cen=0 when hlda=1", outs);
            end
            n_checks++;
            if (cen && aen_n) begin
                n_fail++;
                $display("FAIL invariant_cen: got outs=%b required aen_n=0 when cen=1", outs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        hrq = 1'b0; s_n = 3'b111; lock_n = 1'b1;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", outs, O_CPU);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required %b", outs, O_CPU);
        end
    endtask

    task automatic test_grant();
        logic [4:0] exp_seq [4] = '{O_CENO, O_AENO, O_DMA, O_DMA};
        do_reset();
        hrq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (outs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL grant_edge%0d: got %b required %b", i + 1, outs, exp_seq[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (outs !== O_DMA) begin
                n_fail++;
                $display("FAIL dma_hold%0d: got %b required %b", i, outs, O_DMA);
            end
        end
    endtask

    task automatic test_release();
        logic [4:0] exp_seq [3] = '{O_AENO, O_CENO, O_CPU};
        hrq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (outs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL release_edge%0d: got %b required %b", i + 1, outs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hrq = 1'b1;
        step(); step(); step();
        n_checks++;
        if (outs !== O_DMA) begin
            n_fail++;
            $display("FAIL b2b_dma: got %b required %b", outs, O_DMA);
        end
        hrq = 1'b0;
        step();
        hrq = 1'b1;
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL b2b_rel_cen: got %b required %b", outs, O_CENO);
        end
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL b2b_cpu_entry: got %b required %b", outs, O_CPU);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (outs !== O_CPU) begin
                n_fail++;
                $display("FAIL b2b_min_cpu%0d: got %b required %b", i, outs, O_CPU);
            end
        end
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL b2b_regrant: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b0;
        step();
    endtask

    task automatic test_blocked();
        do_reset();
        hrq = 1'b1; s_n = 3'b000; lock_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (outs !== O_CPU) begin
                n_fail++;
                $display("FAIL busy_hold%0d: got %b required %b", i, outs, O_CPU);
            end
        end
        s_n = 3'b111; lock_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (outs !== O_CPU) begin
                n_fail++;
                $display("FAIL lock_hold%0d: got %b required %b", i, outs, O_CPU);
            end
        end
        lock_n = 1'b1;
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL unblock_grant: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b0;
        step();
    endtask

    task automatic test_abort_cen_off();
        do_reset();
        hrq = 1'b1;
        step();
        hrq = 1'b0;
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL abort_cen_off: got %b required %b", outs, O_CPU);
        end
        // Minimum-tenure counter was not reloaded, so a new request goes straight through
        hrq = 1'b1;
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL abort_cen_off_regrant: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b0;
        step();
    endtask

    task automatic test_abort_aen_off();
        do_reset();
        hrq = 1'b1;
        step();
        step();
        n_checks++;
        if (outs !== O_AENO) begin
            n_fail++;
            $display("FAIL abort_aen_setup: got %b required %b", outs, O_AENO);
        end
        hrq = 1'b0;
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL abort_aen_rel_cen: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b1;
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL abort_aen_cpu: got %b required %b", outs, O_CPU);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (outs !== O_CPU) begin
                n_fail++;
                $display("FAIL abort_aen_min_cpu%0d: got %b required %b", i, outs, O_CPU);
            end
        end
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL abort_aen_regrant: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b0;
        step();
    endtask

    task automatic test_reset_in_dma();
        do_reset();
        hrq = 1'b1;
        step(); step(); step();
        n_checks++;
        if (outs !== O_DMA) begin
            n_fail++;
            $display("FAIL rst_dma_setup: got %b required %b", outs, O_DMA);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (outs !== O_CPU) begin
            n_fail++;
            $display("FAIL rst_in_dma: got %b required %b", outs, O_CPU);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (outs !== O_CENO) begin
            n_fail++;
            $display("FAIL rst_pending_grant: got %b required %b", outs, O_CENO);
        end
        hrq = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_grant();
        test_release();
        test_back_to_back();
        test_blocked();
        test_abort_cen_off();
        test_abort_aen_off();
        test_reset_in_dma();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
